// File: rtl/led_step_controller.sv
// Step-pulse source for the LED chaser: debounces pause/step/dir buttons and
// produces a one-cycle advance strobe, free-running or single-stepped.
module led_step_controller #(
  parameter logic [23:0] BASE_COUNT      = 24'd10_000_000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pause_raw,
  input  logic       btn_step_raw,
  input  logic       btn_dir_raw,
  input  logic [1:0] rate_sel,
  output logic       step_pulse,
  output logic       step_dir,
  output logic       running
);

  localparam int unsigned NB    = 3;
  localparam int unsigned CNT_W = 24;
  localparam int unsigned DEB_W = 16;
  localparam int unsigned BTN_PAUSE = 0;
  localparam int unsigned BTN_STEP  = 1;
  localparam int unsigned BTN_DIR   = 2;
  localparam logic [DEB_W-1:0] DEB_LAST = DEBOUNCE_CYCLES - DEB_W'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  logic [NB-1:0]             raw_c;
  logic [NB-1:0]             sync1_q, sync2_q;
  logic [NB-1:0]             deb_q, deb_d, deb_prev_q;
  logic [NB-1:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [NB-1:0]             press_c;

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          period_last_c;
  logic                      terminal_c;
  logic                      step_pulse_q, dir_q, running_q;

  assign raw_c = {btn_dir_raw, btn_step_raw, btn_pause_raw};

  // Debounce: the level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_cnt_d[i] = '0;
        deb_d[i]     = sync2_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= raw_c;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  // Press event on the rising edge of the debounced level only.
  assign press_c = deb_q & ~deb_prev_q;

  // ">=" lets a switch to a shorter period fire immediately instead of wrapping.
  assign period_last_c = (BASE_COUNT >> rate_sel) - CNT_W'(1);
  assign terminal_c    = (cnt_q >= period_last_c) && !step_pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      step_pulse_q <= 1'b0;
      dir_q        <= 1'b0;
      running_q    <= 1'b1;
    end else begin
      step_pulse_q <= 1'b0;
      if (press_c[BTN_DIR]) begin
        dir_q <= ~dir_q;
      end
      case (state_q)
        ST_RUN: begin
          if (terminal_c) begin
            cnt_q        <= '0;
            step_pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (press_c[BTN_PAUSE]) begin
            state_q   <= ST_PAUSED;
            running_q <= 1'b0;
          end
        end
        ST_PAUSED: begin
          // Pause beats step; a step right behind a final run pulse is dropped.
          if (press_c[BTN_PAUSE]) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            cnt_q     <= '0;
          end else if (press_c[BTN_STEP] && !step_pulse_q) begin
            state_q      <= ST_STEP;
            step_pulse_q <= 1'b1;
          end
        end
        ST_STEP: begin
          state_q <= ST_PAUSED;
        end
        default: begin
          state_q   <= ST_RUN;
          running_q <= 1'b1;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  assign step_pulse = step_pulse_q;
  assign step_dir   = dir_q;
  assign running    = running_q;

endmodule

// File: tb/tb_led_step_controller.sv
// Scoreboard bench for led_step_controller: a cycle-level reference model fed by
// button events placed at their debounced arrival time predicts every step pulse.
module tb_led_step_controller;

  localparam int BASE = 16;
  localparam int DEB  = 4;
  localparam int MAXC = 16384;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_pause_raw = 1'b0;
  logic       btn_step_raw = 1'b0;
  logic       btn_dir_raw = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic       step_pulse;
  logic       step_dir;
  logic       running;

  led_step_controller #(
    .BASE_COUNT      (24'd16),
    .DEBOUNCE_CYCLES (16'd4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_pause_raw (btn_pause_raw),
    .btn_step_raw  (btn_step_raw),
    .btn_dir_raw   (btn_dir_raw),
    .rate_sel      (rate_sel),
    .step_pulse    (step_pulse),
    .step_dir      (step_dir),
    .running       (running)
  );

  always #5 clk = ~clk;

  // Debounced press events, indexed by the clock edge at which the design acts on them.
  bit pause_at [MAXC];
  bit step_at  [MAXC];
  bit dir_at   [MAXC];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int pulses_seen = 0;
  int last_pulse_cyc = -1;
  int last_pulse_dir = -1;

  // Reference model: 0 = running, 1 = paused, 2 = single step in progress.
  int m_state = 0;
  int m_cnt = 0;
  bit m_dir = 1'b0;
  bit m_pulse = 1'b0;

  typedef struct {
    int cyc;
    bit dir;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Model advances at every rising edge and queues each pulse it predicts.
  initial forever begin
    bit pe, se, de, was_pulse;
    int period;
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_state = 0;
      m_cnt   = 0;
      m_dir   = 1'b0;
      m_pulse = 1'b0;
    end else begin
      pe = (cyc < MAXC) ? pause_at[cyc] : 1'b0;
      se = (cyc < MAXC) ? step_at[cyc]  : 1'b0;
      de = (cyc < MAXC) ? dir_at[cyc]   : 1'b0;
      was_pulse = m_pulse;
      m_pulse = 1'b0;
      if (de) m_dir = !m_dir;
      if (m_state == 0) begin
        period = BASE >> int'(rate_sel);
        if (!was_pulse && m_cnt >= period - 1) begin
          m_cnt   = 0;
          m_pulse = 1'b1;
        end else begin
          m_cnt++;
        end
        if (pe) m_state = 1;
      end else if (m_state == 1) begin
        if (pe) begin
          m_state = 0;
          m_cnt   = 0;
        end else if (se && !was_pulse) begin
          m_state = 2;
          m_pulse = 1'b1;
        end
      end else begin
        m_state = 1;
      end
      if (m_pulse) sb_q.push_back('{cyc, m_dir});
    end
  end

  // Monitor: compares levels every cycle and pops the scoreboard on each pulse.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (cyc > 0) begin
      chk("running", int'(running), int'(m_state == 0));
      chk("step_dir", int'(step_dir), int'(m_dir));
      if (step_pulse) begin
        pulses_seen++;
        last_pulse_cyc = cyc;
        last_pulse_dir = int'(step_dir);
        chk("pulse_expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_dir", int'(step_dir), int'(e.dir));
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        chk("missed_pulse", int'(step_pulse), 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Hold the selected buttons for 'hold' cycles, then leave time for release to settle.
  task automatic press(input bit p, input bit s, input bit d, input int hold);
    int at;
    at = cyc + 3 + DEB;
    if (hold >= DEB && at < MAXC) begin
      if (p) pause_at[at] = 1'b1;
      if (s) step_at[at]  = 1'b1;
      if (d) dir_at[at]   = 1'b1;
    end
    btn_pause_raw = p;
    btn_step_raw  = s;
    btn_dir_raw   = d;
    tick(hold);
    btn_pause_raw = 1'b0;
    btn_step_raw  = 1'b0;
    btn_dir_raw   = 1'b0;
    tick(DEB + 4);
  endtask

  task automatic wait_cnt(input int t);
    int k;
    k = 0;
    while (!(m_state == 0 && m_cnt == t) && k < 200) begin
      tick(1);
      k++;
    end
    chk("wait_cnt_reached", int'(m_state == 0 && m_cnt == t), 1);
  endtask

  initial begin
    int p0, n0;
    tick(3);
    reset = 1'b0;
    chk("rst_step_pulse", int'(step_pulse), 0);
    chk("rst_running", int'(running), 1);
    chk("rst_step_dir", int'(step_dir), 0);

    // Free-running cadence from reset.
    p0 = pulses_seen;
    tick(100);
    chk("s1_pulse_count", pulses_seen - p0, 6);

    // Rate change to a shorter period while the count is already past it.
    wait_cnt(10);
    rate_sel = 2'd3;
    p0 = pulses_seen;
    n0 = cyc;
    tick(20);
    chk("s2_pulse_count", pulses_seen - p0, 10);
    chk("s2_first_after_switch", int'(sb_q.size()), 0);
    rate_sel = 2'd0;
    tick(20);

    // Glitch is ignored, a long hold pauses.
    press(1'b1, 1'b0, 1'b0, 3);
    chk("s3_glitch_running", int'(running), 1);
    press(1'b1, 1'b0, 1'b0, 6);
    chk("s3_paused_running", int'(running), 0);
    p0 = pulses_seen;
    tick(40);
    chk("s3_no_pulses", pulses_seen - p0, 0);

    // Single step while paused, then pause+step together resumes with no pulse.
    p0 = pulses_seen;
    press(1'b0, 1'b1, 1'b0, 5);
    chk("s4_step_one_pulse", pulses_seen - p0, 1);
    chk("s4_step_running", int'(running), 0);
    p0 = pulses_seen;
    press(1'b1, 1'b1, 1'b0, 5);
    chk("s4_resume_running", int'(running), 1);
    tick(9);
    chk("s4_no_early_pulse", pulses_seen - p0, 0);
    tick(1);
    chk("s4_full_period_pulse", pulses_seen - p0, 1);

    // Direction press landing on a terminal count.
    wait_cnt(9);
    n0 = cyc;
    press(1'b0, 1'b0, 1'b1, 5);
    chk("s5_pulse_cycle", last_pulse_cyc, n0 + 7);
    chk("s5_pulse_dir", last_pulse_dir, 1);
    press(1'b0, 1'b0, 1'b1, 5);
    chk("s5_dir_back", int'(step_dir), 0);

    // Reset while paused with direction set.
    press(1'b0, 1'b0, 1'b1, 5);
    wait_cnt(2);
    press(1'b1, 1'b0, 1'b0, 5);
    chk("s6_pre_running", int'(running), 0);
    chk("s6_pre_dir", int'(step_dir), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("s6_rst_step_pulse", int'(step_pulse), 0);
    chk("s6_rst_running", int'(running), 1);
    chk("s6_rst_step_dir", int'(step_dir), 0);
    p0 = pulses_seen;
    tick(100);
    chk("s6_pulse_count", pulses_seen - p0, 6);

    // Randomized button traffic, rate changes and occasional resets.
    for (int it = 0; it < 120; it++) begin
      bit p, s, d;
      if ($urandom_range(0, 3) == 0) rate_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 2));
        reset = 1'b0;
      end
      p = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (!p && !s && !d) s = 1'b1;
      press(p, s, d, $urandom_range(1, 7));
      tick($urandom_range(0, 20));
    end

    tick(40);
    chk("scoreboard_drained", int'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
